// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-stage hazard bus between the decode stage (master) and the scoreboard (slave).
interface hazard_scoreboard_if #(parameter int STALL_CNT_W = 16);
  logic                   enable;
  logic                   flush;
  logic [3:0]             id_src_gp;
  logic                   id_src_en;
  logic [3:0]             id_tgt_gp;
  logic                   id_tgt_rd_en;
  logic                   id_wr_en;
  logic [1:0]             id_wr_lat;
  logic                   stall_out;
  logic [15:0]            busy_mask;
  logic [STALL_CNT_W-1:0] stall_cnt;
  modport master (
    output enable, flush, id_src_gp, id_src_en, id_tgt_gp, id_tgt_rd_en, id_wr_en, id_wr_lat,
    input  stall_out, busy_mask, stall_cnt
  );
  modport slave (
    input  enable, flush, id_src_gp, id_src_en, id_tgt_gp, id_tgt_rd_en, id_wr_en, id_wr_lat,
    output stall_out, busy_mask, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write counters driving the decode stall, busy mask and stall counter.
module hazard_scoreboard #(
  parameter int STALL_CNT_W = 16
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave bus
);
  logic [15:0][1:0]       cnt_q, cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [15:0]            busy;
  logic                   stall, issue;
  always_comb begin
    stall = (bus.id_src_en && cnt_q[bus.id_src_gp] != 2'd0) ||
            (bus.id_tgt_rd_en && cnt_q[bus.id_tgt_gp] != 2'd0);
    issue = bus.enable && !stall && !bus.flush && bus.id_wr_en && bus.id_tgt_gp != 4'd0;
    busy  = '0;
    cnt_d = cnt_q;
    for (int r = 1; r < 16; r++) begin
      busy[r] = cnt_q[r] != 2'd0;
      // the issuing register takes its new latency instead of decrementing
      if (bus.enable)
        cnt_d[r] = bus.flush ? 2'd0 :
                   (issue && bus.id_tgt_gp == 4'(r)) ? bus.id_wr_lat :
                   busy[r] ? cnt_q[r] - 2'd1 : 2'd0;
    end
    cnt_d[0] = 2'd0;
    stall_cnt_d = (bus.enable && stall && !bus.flush && stall_cnt_q != '1) ?
                  stall_cnt_q + STALL_CNT_W'(1) : stall_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign bus.stall_out = stall;
  assign bus.busy_mask = busy;
  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed self-checking bench for hazard_scoreboard.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  hazard_scoreboard_if #(.STALL_CNT_W(16)) bus ();
  hazard_scoreboard #(.STALL_CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic src_en, input logic [3:0] src, input logic rd_en,
                       input logic [3:0] tgt, input logic wr_en, input logic [1:0] lat);
    bus.id_src_en    = src_en;
    bus.id_src_gp    = src;
    bus.id_tgt_rd_en = rd_en;
    bus.id_tgt_gp    = tgt;
    bus.id_wr_en     = wr_en;
    bus.id_wr_lat    = lat;
    #1;
  endtask
  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 2'd0);
  endtask
  initial begin
    bus.enable = 1'b1;
    bus.flush  = 1'b0;
    idle();
    #6;
    chk("reset_busy", 32'(bus.busy_mask), 32'h0);
    chk("reset_cnt", 32'(bus.stall_cnt), 32'h0);
    chk("reset_stall", 32'(bus.stall_out), 32'h0);
    #5 rst = 1'b0;
    tick();
    // r0 is never tracked
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 2'd3);
    tick();
    chk("r0_write_busy", 32'(bus.busy_mask), 32'h0);
    drive(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 2'd0);
    chk("r0_read_stall", 32'(bus.stall_out), 32'h0);
    // r3 lat 3 then dependent read: stalls while cnt3 is 3,2,1
    drive(1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 2'd3);
    chk("r3_issue_nostall", 32'(bus.stall_out), 32'h0);
    tick();
    chk("r3_busy0", 32'(bus.busy_mask), 32'h0008);
    drive(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 2'd0);
    chk("r3_stall0", 32'(bus.stall_out), 32'h1);
    tick();
    chk("r3_busy1", 32'(bus.busy_mask), 32'h0008);
    chk("r3_stall1", 32'(bus.stall_out), 32'h1);
    chk("r3_cnt1", 32'(bus.stall_cnt), 32'd1);
    tick();
    chk("r3_busy2", 32'(bus.busy_mask), 32'h0008);
    chk("r3_stall2", 32'(bus.stall_out), 32'h1);
    chk("r3_cnt2", 32'(bus.stall_cnt), 32'd2);
    bus.enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_busy", 32'(bus.busy_mask), 32'h0008);
      chk("hold_stall", 32'(bus.stall_out), 32'h1);
      chk("hold_cnt", 32'(bus.stall_cnt), 32'd2);
    end
    bus.enable = 1'b1;
    tick();
    chk("r3_busy3", 32'(bus.busy_mask), 32'h0000);
    chk("r3_stall3", 32'(bus.stall_out), 32'h0);
    chk("r3_cnt3", 32'(bus.stall_cnt), 32'd3);
    // r5 lat 3 overridden by lat 1
    drive(1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 2'd3);
    tick();
    chk("r5_busy_a", 32'(bus.busy_mask), 32'h0020);
    drive(1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 2'd1);
    tick();
    chk("r5_busy_b", 32'(bus.busy_mask), 32'h0020);
    idle();
    tick();
    chk("r5_busy_c", 32'(bus.busy_mask), 32'h0000);
    // r2 lat 2 and r4 lat 3 back to back
    drive(1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 2'd2);
    tick();
    chk("r24_busy_a", 32'(bus.busy_mask), 32'h0004);
    drive(1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 2'd3);
    tick();
    chk("r24_busy_b", 32'(bus.busy_mask), 32'h0014);
    drive(1'b0, 4'd0, 1'b1, 4'd4, 1'b0, 2'd0);
    chk("r4_tgt_read_stall", 32'(bus.stall_out), 32'h1);
    idle();
    tick();
    chk("r24_busy_c", 32'(bus.busy_mask), 32'h0010);
    tick();
    chk("r24_busy_d", 32'(bus.busy_mask), 32'h0010);
    tick();
    chk("r24_busy_e", 32'(bus.busy_mask), 32'h0000);
    chk("r24_cnt", 32'(bus.stall_cnt), 32'd3);
    // read and write of the same idle register: no self-stall
    drive(1'b1, 4'd8, 1'b1, 4'd8, 1'b1, 2'd2);
    chk("self_nostall", 32'(bus.stall_out), 32'h0);
    tick();
    chk("self_busy", 32'(bus.busy_mask), 32'h0100);
    idle();
    tick();
    tick();
    chk("self_busy_done", 32'(bus.busy_mask), 32'h0000);
    // flush with r1, r7, r9 pending and a concurrent write to r10
    drive(1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 2'd3);
    tick();
    drive(1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 2'd3);
    tick();
    drive(1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 2'd3);
    tick();
    chk("pre_flush_busy", 32'(bus.busy_mask), 32'h0282);
    bus.flush = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 4'd10, 1'b1, 2'd3);
    tick();
    bus.flush = 1'b0;
    idle();
    chk("flush_busy", 32'(bus.busy_mask), 32'h0000);
    chk("flush_cnt", 32'(bus.stall_cnt), 32'd3);
    // flush ignored while frozen
    drive(1'b0, 4'd0, 1'b0, 4'd12, 1'b1, 2'd3);
    tick();
    idle();
    bus.enable = 1'b0;
    bus.flush  = 1'b1;
    tick();
    chk("frozen_flush_busy", 32'(bus.busy_mask), 32'h1000);
    // flush during a stall: stall_out stays combinational, no count
    bus.enable = 1'b1;
    drive(1'b1, 4'd12, 1'b0, 4'd0, 1'b0, 2'd0);
    chk("flush_stall_out", 32'(bus.stall_out), 32'h1);
    tick();
    bus.flush = 1'b0;
    idle();
    chk("flush_stall_busy", 32'(bus.busy_mask), 32'h0000);
    chk("flush_stall_cnt", 32'(bus.stall_cnt), 32'd3);
    // reset asserted mid-stall
    drive(1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 2'd3);
    tick();
    drive(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 2'd0);
    tick();
    chk("midstall_cnt", 32'(bus.stall_cnt), 32'd4);
    rst = 1'b1;
    #1;
    chk("midrst_stall", 32'(bus.stall_out), 32'h0);
    chk("midrst_busy", 32'(bus.busy_mask), 32'h0000);
    chk("midrst_cnt", 32'(bus.stall_cnt), 32'd0);
    rst = 1'b0;
    // saturation: read and write r6 lat 3 gives 3 stalls per 4 cycles
    drive(1'b1, 4'd6, 1'b0, 4'd6, 1'b1, 2'd3);
    repeat (87000) tick();
    chk("sat_pre", 32'(bus.stall_cnt), 32'd65250);
    repeat (600) tick();
    chk("sat_ffff", 32'(bus.stall_cnt), 32'h0000ffff);
    repeat (8) tick();
    chk("sat_stick", 32'(bus.stall_cnt), 32'h0000ffff);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
